// File: rtl/mfp_seq_divider_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
// Holds the FSM encoding and the saturation-limit helpers.
package mfp_seq_divider_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

    function automatic longint sat_max(input int unsigned w, input bit is_unsigned);
        return is_unsigned ? (longint'(1) << w) - 1 : (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w, input bit is_unsigned);
        return is_unsigned ? longint'(0) : -(longint'(1) << (w - 1));
    endfunction

    // Counter width for n iterations; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mfp_seq_divider_if.sv
// Operand/result handshake bundle of the divider.
// The master side supplies operands and consumes results.
interface mfp_seq_divider_if #(
    parameter int unsigned NumW = 8,
    parameter int unsigned DenW = 8,
    parameter int unsigned OutW = 8
) ();

    logic            in_valid;
    logic            in_ready;
    logic [NumW-1:0] num;
    logic [DenW-1:0] den;
    logic            out_valid;
    logic            out_ready;
    logic [OutW-1:0] quo;
    logic            ovf;
    logic            dz;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quo, ovf, dz
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quo, ovf, dz
    );

endinterface

// File: rtl/mfp_seq_divider_sat.sv
// Clamps a signed (or unsigned) value into OutW bits and flags clipping.
// Works for any InW/OutW ratio by comparing in a common widened domain.
module mfp_seq_divider_sat
    import mfp_seq_divider_pkg::*;
#(
    parameter int unsigned InW        = 9,
    parameter int unsigned OutW       = 8,
    parameter bit          IsUnsigned = 1'b0
) (
    input  logic [InW-1:0]  val_i,
    output logic [OutW-1:0] val_o,
    output logic            ovf_o
);

    localparam int unsigned W = ((InW > OutW) ? InW : OutW) + 1;
    localparam logic signed [W-1:0] MaxV = W'(sat_max(OutW, IsUnsigned));
    localparam logic signed [W-1:0] MinV = W'(sat_min(OutW, IsUnsigned));

    logic signed [W-1:0] ext;

    always_comb begin
        ext   = IsUnsigned ? $signed({{(W - InW){1'b0}}, val_i})
                           : $signed({{(W - InW){val_i[InW-1]}}, val_i});
        val_o = ext[OutW-1:0];
        ovf_o = 1'b0;
        if (ext > MaxV) begin
            val_o = MaxV[OutW-1:0];
            ovf_o = 1'b1;
        end else if (ext < MinV) begin
            val_o = MinV[OutW-1:0];
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/mfp_seq_divider.sv
// Iterative radix-2 restoring divider: quo = trunc0((num << FracW) / den),
// one quotient bit per cycle, saturated to OutW with overflow/divide-by-zero flags.
module mfp_seq_divider
    import mfp_seq_divider_pkg::*;
#(
    parameter int unsigned NumW       = 8,
    parameter int unsigned DenW       = 8,
    parameter int unsigned OutW       = 8,
    parameter int unsigned FracW      = 0,
    parameter bit          IsUnsigned = 1'b0
) (
    input logic clk_i,
    input logic rst_ni,
    mfp_seq_divider_if.slave bus
);

    localparam int unsigned N    = NumW + FracW;
    localparam int unsigned CntW = cnt_width(N);
    localparam logic [OutW-1:0] QuoMax = OutW'(sat_max(OutW, IsUnsigned));
    localparam logic [OutW-1:0] QuoMin = OutW'(sat_min(OutW, IsUnsigned));

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    dq_q, dq_d;      // dividend shifts out the top, quotient shifts in below
    logic [DenW:0]   rem_q, rem_d;
    logic [DenW:0]   den_q, den_d;
    logic            sign_q, sign_d;
    logic [OutW-1:0] quo_q, quo_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;

    logic            num_neg, den_neg;
    logic [NumW:0]   num_ext, num_mag;
    logic [DenW:0]   den_ext, den_mag;
    logic [DenW:0]   rem_sh;
    logic            ge;
    logic [N:0]      sat_in;
    logic [OutW-1:0] sat_out;
    logic            sat_ovf;

    always_comb begin
        num_neg = !IsUnsigned && bus.num[NumW-1];
        den_neg = !IsUnsigned && bus.den[DenW-1];
        num_ext = {num_neg, bus.num};
        den_ext = {den_neg, bus.den};
        num_mag = num_neg ? -num_ext : num_ext;
        den_mag = den_neg ? -den_ext : den_ext;
        rem_sh  = (DenW + 1)'({rem_q, dq_q[N-1]});
        ge      = (rem_sh >= den_q);
        sat_in  = sign_q ? -{1'b0, dq_q} : {1'b0, dq_q};
    end

    mfp_seq_divider_sat #(
        .InW        (N + 1),
        .OutW       (OutW),
        .IsUnsigned (IsUnsigned)
    ) u_sat (
        .val_i (sat_in),
        .val_o (sat_out),
        .ovf_o (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        den_d   = den_q;
        sign_d  = sign_q;
        quo_d   = quo_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dq_d    = N'(num_mag) << FracW;
                    den_d   = den_mag;
                    sign_d  = num_neg ^ den_neg;
                    rem_d   = '0;
                    cnt_d   = CntW'(N - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rem_d = ge ? rem_sh - den_q : rem_sh;
                dq_d  = N'({dq_q, ge});
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                if (den_q == '0) begin
                    quo_d = sign_q ? QuoMin : QuoMax;
                    ovf_d = 1'b1;
                    dz_d  = 1'b1;
                end else begin
                    quo_d = sat_out;
                    ovf_d = sat_ovf;
                    dz_d  = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            sign_q  <= 1'b0;
            quo_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            sign_q  <= sign_d;
            quo_q   <= quo_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.quo       = quo_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;

endmodule

// File: tb/tb_mfp_seq_divider.sv
// Directed bench for mfp_seq_divider: signed 8/8/8, signed FracW=4 and unsigned instances.
module tb_mfp_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mfp_seq_divider_if #(.NumW(8), .DenW(8), .OutW(8)) if_a ();
    mfp_seq_divider_if #(.NumW(8), .DenW(8), .OutW(8)) if_f ();
    mfp_seq_divider_if #(.NumW(8), .DenW(8), .OutW(8)) if_u ();

    mfp_seq_divider #(.NumW(8), .DenW(8), .OutW(8), .FracW(0), .IsUnsigned(1'b0)) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_a)
    );

    mfp_seq_divider #(.NumW(8), .DenW(8), .OutW(8), .FracW(4), .IsUnsigned(1'b0)) u_dut_f (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_f)
    );

    mfp_seq_divider #(.NumW(8), .DenW(8), .OutW(8), .FracW(0), .IsUnsigned(1'b1)) u_dut_u (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if_u)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Signed 8-bit instance; lat counts cycles after the accept cycle.
    task automatic run_a(input logic [7:0] n, input logic [7:0] d, input int exp_q,
                         input bit exp_ovf, input bit exp_dz, input int hold,
                         input bit pulse, input string tag);
        int lat;
        @(negedge clk);
        check_eq({tag, " rdy"}, 32'(if_a.in_ready), 1);
        if_a.num = n;
        if_a.den = d;
        if_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        lat = 1;
        while (!if_a.out_valid && lat < 40) begin
            if (pulse && lat == 3) begin
                if_a.num = 8'd1;
                if_a.den = 8'd1;
                if_a.in_valid = 1'b1;
                check_eq({tag, " busy"}, 32'(if_a.in_ready), 0);
            end else begin
                if_a.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if_a.in_valid = 1'b0;
        check_eq({tag, " lat"}, lat, 10);
        check_eq({tag, " quo"}, $signed(if_a.quo), exp_q);
        check_eq({tag, " ovf"}, 32'(if_a.ovf), 32'(exp_ovf));
        check_eq({tag, " dz"}, 32'(if_a.dz), 32'(exp_dz));
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check_eq({tag, " hold quo"}, $signed(if_a.quo), exp_q);
            check_eq({tag, " hold vld"}, 32'(if_a.out_valid), 1);
            check_eq({tag, " hold rdy"}, 32'(if_a.in_ready), 0);
        end
        if_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if_a.out_ready = 1'b0;
        check_eq({tag, " drop"}, 32'(if_a.out_valid), 0);
    endtask

    task automatic run_f(input logic [7:0] n, input logic [7:0] d, input int exp_q,
                         input bit exp_ovf, input string tag);
        int cyc;
        @(negedge clk);
        if_f.num = n;
        if_f.den = d;
        if_f.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if_f.in_valid = 1'b0;
        cyc = 0;
        while (!if_f.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, " vld"}, 32'(if_f.out_valid), 1);
        check_eq({tag, " quo"}, $signed(if_f.quo), exp_q);
        check_eq({tag, " ovf"}, 32'(if_f.ovf), 32'(exp_ovf));
        if_f.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if_f.out_ready = 1'b0;
    endtask

    task automatic run_u(input logic [7:0] n, input logic [7:0] d, input int exp_q,
                         input bit exp_ovf, input bit exp_dz, input string tag);
        int cyc;
        @(negedge clk);
        if_u.num = n;
        if_u.den = d;
        if_u.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if_u.in_valid = 1'b0;
        cyc = 0;
        while (!if_u.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, " vld"}, 32'(if_u.out_valid), 1);
        check_eq({tag, " quo"}, 32'(if_u.quo), exp_q);
        check_eq({tag, " ovf"}, 32'(if_u.ovf), 32'(exp_ovf));
        check_eq({tag, " dz"}, 32'(if_u.dz), 32'(exp_dz));
        if_u.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if_u.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.in_valid = 1'b0; if_a.out_ready = 1'b0; if_a.num = '0; if_a.den = '0;
        if_f.in_valid = 1'b0; if_f.out_ready = 1'b0; if_f.num = '0; if_f.den = '0;
        if_u.in_valid = 1'b0; if_u.out_ready = 1'b0; if_u.num = '0; if_u.den = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset rdy", 32'(if_a.in_ready), 1);
        check_eq("reset vld", 32'(if_a.out_valid), 0);
        check_eq("reset quo", 32'(if_a.quo), 0);
        check_eq("reset ovf", 32'(if_a.ovf), 0);
        check_eq("reset dz", 32'(if_a.dz), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_a(8'd100,  8'd7,    14,   1'b0, 1'b0, 0, 1'b0, "100/7");
        run_a(-8'sd100, 8'd7,   -14,  1'b0, 1'b0, 0, 1'b0, "-100/7");
        run_a(8'd100,  -8'sd7,  -14,  1'b0, 1'b0, 0, 1'b0, "100/-7");
        run_a(-8'sd100, -8'sd7, 14,   1'b0, 1'b0, 0, 1'b0, "-100/-7");
        run_a(8'h80,   8'hFF,   127,  1'b1, 1'b0, 0, 1'b0, "-128/-1");
        run_a(8'h80,   8'd1,    -128, 1'b0, 1'b0, 0, 1'b0, "-128/1");
        run_a(8'd127,  8'h80,   0,    1'b0, 1'b0, 0, 1'b0, "127/-128");
        run_a(8'd5,    8'd0,    127,  1'b1, 1'b1, 0, 1'b0, "5/0");
        run_a(-8'sd5,  8'd0,    -128, 1'b1, 1'b1, 0, 1'b0, "-5/0");
        run_a(8'd100,  8'd7,    14,   1'b0, 1'b0, 20, 1'b1, "hold");

        run_f(8'd3,    8'd2,    24,   1'b0, "q4 3/2");
        run_f(-8'sd3,  8'd2,    -24,  1'b0, "q4 -3/2");
        run_f(8'd100,  8'd1,    127,  1'b1, "q4 100/1");

        run_u(8'd255,  8'd1,    255,  1'b0, 1'b0, "u 255/1");
        run_u(8'd255,  8'd2,    127,  1'b0, 1'b0, "u 255/2");
        run_u(8'd255,  8'd255,  1,    1'b0, 1'b0, "u 255/255");
        run_u(8'd200,  8'd0,    255,  1'b1, 1'b1, "u 200/0");

        // Abort an operation mid-iteration.
        @(negedge clk);
        if_a.num = 8'd100;
        if_a.den = 8'd7;
        if_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort vld", 32'(if_a.out_valid), 0);
        check_eq("abort rdy", 32'(if_a.in_ready), 1);
        check_eq("abort quo", 32'(if_a.quo), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("abort idle", 32'(if_a.out_valid), 0);
        run_a(8'd50, 8'd5, 10, 1'b0, 1'b0, 0, 1'b0, "50/5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
